// File: rtl/automatic_garage_door_controller.sv
// Moore FSM driving the up/down garage door motor from a single push-button
// and two end-of-travel limit sensors. Motor outputs are registered.
module automatic_garage_door_controller (
    input  logic CLK,
    input  logic RST,
    input  logic Activate,
    input  logic Up_Max,
    input  logic Dn_Max,
    output logic UP_M,
    output logic DN_M
);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StMvUp = 2'b01,
        StMvDn = 2'b10,
        StBad  = 2'b11
    } state_e;

    state_e state_q, state_d;

    always_comb begin
        state_d = StIdle;
        unique case (state_q)
            StIdle: begin
                if (Activate && Up_Max && !Dn_Max) begin
                    state_d = StMvDn;
                end else if (Activate && Dn_Max && !Up_Max) begin
                    state_d = StMvUp;
                end else begin
                    state_d = StIdle;
                end
            end
            // Travel always continues until the limit in the direction of motion.
            StMvUp:  state_d = Up_Max ? StIdle : StMvUp;
            StMvDn:  state_d = Dn_Max ? StIdle : StMvDn;
            StBad:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs are decoded from the next state so they line up with state_q.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= StIdle;
            UP_M    <= 1'b0;
            DN_M    <= 1'b0;
        end else begin
            state_q <= state_d;
            UP_M    <= (state_d == StMvUp);
            DN_M    <= (state_d == StMvDn);
        end
    end

endmodule

// File: tb/tb_automatic_garage_door_controller.sv
// Directed self-checking bench for the garage door controller FSM.
module tb_automatic_garage_door_controller;

    logic clk;
    logic rst;
    logic activate;
    logic up_max;
    logic dn_max;
    logic up_m;
    logic dn_m;

    int checks = 0;
    int errors = 0;

    automatic_garage_door_controller dut (
        .CLK      (clk),
        .RST      (rst),
        .Activate (activate),
        .Up_Max   (up_max),
        .Dn_Max   (dn_max),
        .UP_M     (up_m),
        .DN_M     (dn_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Motors must never run together; sampled between edges.
    always @(posedge clk) begin
        #3;
        checks++;
        if ((up_m & dn_m) !== 1'b0) begin
            errors++;
            $display("FAIL both_motors: up_m=%b dn_m=%b required not both 1", up_m, dn_m);
        end
    end

    task automatic drive(input logic a, input logic u, input logic d);
        activate = a;
        up_max   = u;
        dn_max   = d;
    endtask

    // Inputs are driven right after a falling edge; sampling happens on a later falling edge.
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if ({up_m, dn_m} !== 2'b00) begin
            errors++;
            $display("FAIL reset_immediate: got %b%b required 00", up_m, dn_m);
        end
        step(1);
        checks++;
        if ({up_m, dn_m} !== 2'b00) begin
            errors++;
            $display("FAIL reset_held: got %b%b required 00", up_m, dn_m);
        end
        rst = 1'b0;
        step(1);
        checks++;
        if ({up_m, dn_m} !== 2'b00) begin
            errors++;
            $display("FAIL reset_release: got %b%b required 00", up_m, dn_m);
        end
        // No sensor asserted: button alone must not start the motor.
        drive(1'b1, 1'b0, 1'b0);
        step(1);
        checks++;
        if ({up_m, dn_m} !== 2'b00) begin
            errors++;
            $display("FAIL idle_no_sensor: got %b%b required 00", up_m, dn_m);
        end
    endtask

    task automatic test_close;
        drive(1'b1, 1'b1, 1'b0);
        step(1);
        checks++;
        if ({up_m, dn_m} !== 2'b01) begin
            errors++;
            $display("FAIL close_start: got %b%b required 01", up_m, dn_m);
        end
    endtask

    task automatic test_reverse;
        drive(1'b1, 1'b0, 1'b1);
        step(1);
        checks++;
        if ({up_m, dn_m} !== 2'b00) begin
            errors++;
            $display("FAIL reverse_idle: got %b%b required 00", up_m, dn_m);
        end
        step(1);
        checks++;
        if ({up_m, dn_m} !== 2'b10) begin
            errors++;
            $display("FAIL reverse_open: got %b%b required 10", up_m, dn_m);
        end
    endtask

    task automatic test_release;
        drive(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step(1);
            checks++;
            if ({up_m, dn_m} !== 2'b10) begin
                errors++;
                $display("FAIL release_keep_open[%0d]: got %b%b required 10", i, up_m, dn_m);
            end
        end
        // Opposite limit while opening is ignored.
        drive(1'b0, 1'b0, 1'b1);
        step(1);
        checks++;
        if ({up_m, dn_m} !== 2'b10) begin
            errors++;
            $display("FAIL open_ignores_dn: got %b%b required 10", up_m, dn_m);
        end
    endtask

    task automatic test_suspend;
        drive(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) begin
            step(1);
            checks++;
            if ({up_m, dn_m} !== 2'b00) begin
                errors++;
                $display("FAIL suspend[%0d]: got %b%b required 00", i, up_m, dn_m);
            end
        end
    endtask

    task automatic test_async_reset;
        drive(1'b1, 1'b1, 1'b0);
        step(1);
        drive(1'b0, 1'b0, 1'b0);
        checks++;
        if ({up_m, dn_m} !== 2'b01) begin
            errors++;
            $display("FAIL async_pre: got %b%b required 01", up_m, dn_m);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (dn_m !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: dn_m=%b required 0 before next edge", dn_m);
        end
        step(1);
        rst = 1'b0;
        step(1);
        checks++;
        if ({up_m, dn_m} !== 2'b00) begin
            errors++;
            $display("FAIL async_restart_idle: got %b%b required 00", up_m, dn_m);
        end
        drive(1'b1, 1'b1, 1'b0);
        step(1);
        checks++;
        if ({up_m, dn_m} !== 2'b01) begin
            errors++;
            $display("FAIL async_restart_close: got %b%b required 01", up_m, dn_m);
        end
    endtask

    // Button held: MV_DN -> IDLE -> MV_UP -> IDLE -> MV_DN with sensor tracking.
    task automatic test_back_to_back;
        logic [1:0] exp_seq [6];
        logic [2:0] in_seq [6];
        exp_seq = '{2'b00, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01};
        in_seq  = '{3'b101, 3'b101, 3'b100, 3'b110, 3'b110, 3'b100};
        for (int i = 0; i < 6; i++) begin
            drive(in_seq[i][2], in_seq[i][1], in_seq[i][0]);
            step(1);
            checks++;
            if ({up_m, dn_m} !== exp_seq[i]) begin
                errors++;
                $display("FAIL held_cycle[%0d]: got %b%b required %b", i, up_m, dn_m,
                         exp_seq[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_close();
        test_reverse();
        test_release();
        test_suspend();
        test_async_reset();
        test_back_to_back();
        step(1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
